// File: rtl/can_frame_monitor.sv
// ----------------------------------------------------------------------------
// can_frame_monitor
//
// Passive bit-level CAN receiver. Watches one node's rx line, recovers bit
// timing by hard sync on the SOF edge, removes stuff bits, checks CRC-15 and
// frame form, and reports decoded standard (11-bit ID) data/remote frames.
// Never drives the bus.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per CAN bit (>= 4)
//   SAMPLE_POINT  bit-counter value at which the line is sampled
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   rx_i           bus level, 1 = recessive, 0 = dominant
//   frame_valid_o  one-cycle pulse when an error-free frame completes
//   id_o           identifier of last valid frame
//   rtr_o          RTR bit of last valid frame
//   dlc_o          DLC of last valid frame (as received, 0..15)
//   data_o         data bytes, first byte at [63:56], unused bytes zero
//   ack_seen_o     ACK slot sampled dominant in last valid frame
//   error_o        one-cycle pulse on protocol error
//   error_code_o   1 stuff, 2 CRC, 3 form, 4 IDE unsupported; held
// ----------------------------------------------------------------------------
module can_frame_monitor #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_POINT = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_i,
    output logic        frame_valid_o,
    output logic [10:0] id_o,
    output logic        rtr_o,
    output logic [3:0]  dlc_o,
    output logic [63:0] data_o,
    output logic        ack_seen_o,
    output logic        error_o,
    output logic [2:0]  error_code_o
);

    localparam int unsigned   CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);
    localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ERR_STUFF = 3'd1;
    localparam logic [2:0] ERR_CRC   = 3'd2;
    localparam logic [2:0] ERR_FORM  = 3'd3;
    localparam logic [2:0] ERR_IDE   = 3'd4;

    typedef enum logic [3:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_ID,
        S_RTR,
        S_IDE,
        S_R0,
        S_DLC,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK,
        S_ACK_DEL,
        S_EOF
    } state_e;

    // CRC-15/CAN, polynomial 0x4599, one destuffed bit per call
    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        crc_step = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic          sof_pend_q, sof_pend_d;
    logic [6:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    run_q, run_d;
    logic          last_q, last_d;
    logic [14:0]   crc_q, crc_d;
    logic [14:0]   crc_rx_q, crc_rx_d;
    logic [10:0]   id_q, id_d;
    logic          rtr_q, rtr_d;
    logic [3:0]    dlc_q, dlc_d;
    logic [63:0]   data_q, data_d;
    logic          ack_q, ack_d;

    logic          frame_valid_q, frame_valid_d;
    logic [10:0]   id_out_q, id_out_d;
    logic          rtr_out_q, rtr_out_d;
    logic [3:0]    dlc_out_q, dlc_out_d;
    logic [63:0]   data_out_q, data_out_d;
    logic          ack_out_q, ack_out_d;
    logic          error_q, error_d;
    logic [2:0]    error_code_q, error_code_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       rx_bit;
    logic       sample;
    logic       fall;
    logic       stuffed;
    logic       data_bit;
    logic       err;
    logic [2:0] err_code;
    logic [3:0] dlc_new;
    logic [3:0] nbytes;
    logic [6:0] data_bits;

    assign rx_bit    = rx_s_q;
    assign sample    = (cnt_q == SAMPLE_CNT);
    assign fall      = rx_prev_q & ~rx_s_q;
    assign nbytes    = (dlc_q > 4'd8) ? 4'd8 : dlc_q;
    assign data_bits = {nbytes, 3'b000};

    // Destuffing spans SOF..last CRC bit; a stuff bit owed after the last
    // CRC bit is consumed while waiting in CRC_DEL.
    assign stuffed = (state_q inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC})
                   || ((state_q == S_CRC_DEL) && (run_q == 3'd5));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_WAIT_IDLE;
            cnt_q         <= '0;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            sof_pend_q    <= 1'b0;
            bit_cnt_q     <= '0;
            run_q         <= '0;
            last_q        <= 1'b1;
            crc_q         <= '0;
            crc_rx_q      <= '0;
            id_q          <= '0;
            rtr_q         <= 1'b0;
            dlc_q         <= '0;
            data_q        <= '0;
            ack_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            id_out_q      <= '0;
            rtr_out_q     <= 1'b0;
            dlc_out_q     <= '0;
            data_out_q    <= '0;
            ack_out_q     <= 1'b0;
            error_q       <= 1'b0;
            error_code_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_meta_q     <= rx_i;
            rx_s_q        <= rx_meta_q;
            rx_prev_q     <= rx_s_q;
            sof_pend_q    <= sof_pend_d;
            bit_cnt_q     <= bit_cnt_d;
            run_q         <= run_d;
            last_q        <= last_d;
            crc_q         <= crc_d;
            crc_rx_q      <= crc_rx_d;
            id_q          <= id_d;
            rtr_q         <= rtr_d;
            dlc_q         <= dlc_d;
            data_q        <= data_d;
            ack_q         <= ack_d;
            frame_valid_q <= frame_valid_d;
            id_out_q      <= id_out_d;
            rtr_out_q     <= rtr_out_d;
            dlc_out_q     <= dlc_out_d;
            data_out_q    <= data_out_d;
            ack_out_q     <= ack_out_d;
            error_q       <= error_d;
            error_code_q  <= error_code_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        sof_pend_d    = sof_pend_q;
        bit_cnt_d     = bit_cnt_q;
        run_d         = run_q;
        last_d        = last_q;
        crc_d         = crc_q;
        crc_rx_d      = crc_rx_q;
        id_d          = id_q;
        rtr_d         = rtr_q;
        dlc_d         = dlc_q;
        data_d        = data_q;
        ack_d         = ack_q;
        frame_valid_d = 1'b0;
        id_out_d      = id_out_q;
        rtr_out_d     = rtr_out_q;
        dlc_out_d     = dlc_out_q;
        data_out_d    = data_out_q;
        ack_out_d     = ack_out_q;
        error_d       = 1'b0;
        error_code_d  = error_code_q;
        err           = 1'b0;
        err_code      = '0;
        data_bit      = 1'b0;
        dlc_new       = dlc_q;

        // Stuff-bit classification; data_bit marks a bit that belongs to
        // the destuffed stream and is consumed by the field logic below.
        if (sample && stuffed) begin
            if (run_q == 3'd5) begin
                if (rx_bit == last_q) begin
                    err      = 1'b1;
                    err_code = ERR_STUFF;
                end else begin
                    run_d  = 3'd1;
                    last_d = rx_bit;
                end
            end else begin
                data_bit = 1'b1;
                run_d    = (rx_bit == last_q) ? run_q + 3'd1 : 3'd1;
                last_d   = rx_bit;
            end
        end

        unique case (state_q)
            S_WAIT_IDLE: begin
                if (sample) begin
                    if (!rx_bit) begin
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == 7'd10) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end

            S_IDLE: begin
                if (fall) begin
                    cnt_d      = '0;
                    sof_pend_d = 1'b1;
                end else if (sample && sof_pend_q) begin
                    sof_pend_d = 1'b0;
                    if (!rx_bit) begin
                        // SOF: dominant bit is the first member of the run
                        // and of the CRC stream (contributes 0 from init 0).
                        state_d   = S_ID;
                        bit_cnt_d = '0;
                        run_d     = 3'd1;
                        last_d    = 1'b0;
                        crc_d     = crc_step(15'h0000, 1'b0);
                        crc_rx_d  = '0;
                        id_d      = '0;
                        rtr_d     = 1'b0;
                        dlc_d     = '0;
                        data_d    = '0;
                        ack_d     = 1'b0;
                    end
                end
            end

            S_ID: begin
                if (data_bit) begin
                    crc_d = crc_step(crc_q, rx_bit);
                    id_d  = {id_q[9:0], rx_bit};
                    if (bit_cnt_q == 7'd10) begin
                        state_d   = S_RTR;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end

            S_RTR: begin
                if (data_bit) begin
                    crc_d   = crc_step(crc_q, rx_bit);
                    rtr_d   = rx_bit;
                    state_d = S_IDE;
                end
            end

            S_IDE: begin
                if (data_bit) begin
                    crc_d = crc_step(crc_q, rx_bit);
                    if (rx_bit) begin
                        err      = 1'b1;
                        err_code = ERR_IDE;
                    end else begin
                        state_d = S_R0;
                    end
                end
            end

            S_R0: begin
                if (data_bit) begin
                    crc_d     = crc_step(crc_q, rx_bit);
                    state_d   = S_DLC;
                    bit_cnt_d = '0;
                end
            end

            S_DLC: begin
                if (data_bit) begin
                    crc_d   = crc_step(crc_q, rx_bit);
                    dlc_new = {dlc_q[2:0], rx_bit};
                    dlc_d   = dlc_new;
                    if (bit_cnt_q == 7'd3) begin
                        bit_cnt_d = '0;
                        state_d   = (rtr_q || (dlc_new == 4'd0)) ? S_CRC : S_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end

            S_DATA: begin
                if (data_bit) begin
                    crc_d = crc_step(crc_q, rx_bit);
                    data_d[6'd63 - bit_cnt_q[5:0]] = rx_bit;
                    if (bit_cnt_q == data_bits - 7'd1) begin
                        state_d   = S_CRC;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end

            S_CRC: begin
                if (data_bit) begin
                    crc_rx_d = {crc_rx_q[13:0], rx_bit};
                    if (bit_cnt_q == 7'd14) begin
                        if (crc_rx_d != crc_q) begin
                            err      = 1'b1;
                            err_code = ERR_CRC;
                        end else begin
                            state_d   = S_CRC_DEL;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end

            S_CRC_DEL: begin
                // run_q == 5 means this sample is the trailing stuff bit,
                // already handled above; the delimiter follows it.
                if (sample && (run_q != 3'd5)) begin
                    if (!rx_bit) begin
                        err      = 1'b1;
                        err_code = ERR_FORM;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end

            S_ACK: begin
                if (sample) begin
                    ack_d   = ~rx_bit;
                    state_d = S_ACK_DEL;
                end
            end

            S_ACK_DEL: begin
                if (sample) begin
                    if (!rx_bit) begin
                        err      = 1'b1;
                        err_code = ERR_FORM;
                    end else begin
                        state_d   = S_EOF;
                        bit_cnt_d = '0;
                    end
                end
            end

            S_EOF: begin
                if (sample) begin
                    if (!rx_bit) begin
                        err      = 1'b1;
                        err_code = ERR_FORM;
                    end else if (bit_cnt_q == 7'd6) begin
                        frame_valid_d = 1'b1;
                        id_out_d      = id_q;
                        rtr_out_d     = rtr_q;
                        dlc_out_d     = dlc_q;
                        data_out_d    = data_q;
                        ack_out_d     = ack_q;
                        state_d       = S_IDLE;
                        sof_pend_d    = 1'b0;
                        bit_cnt_d     = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end

            default: begin
                state_d   = S_WAIT_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (err) begin
            error_d      = 1'b1;
            error_code_d = err_code;
            state_d      = S_WAIT_IDLE;
            bit_cnt_d    = '0;
            sof_pend_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign frame_valid_o = frame_valid_q;
    assign id_o          = id_out_q;
    assign rtr_o         = rtr_out_q;
    assign dlc_o         = dlc_out_q;
    assign data_o        = data_out_q;
    assign ack_seen_o    = ack_out_q;
    assign error_o       = error_q;
    assign error_code_o  = error_code_q;

endmodule

// File: tb/tb_can_frame_monitor.sv
// ----------------------------------------------------------------------------
// tb_can_frame_monitor
//
// Drives CAN frames built by a small transmitter model (bitwise long-division
// CRC, bit stuffing) onto rx_i. Expected outcomes are queued when a frame is
// issued; a monitor process compares them whenever the DUT pulses
// frame_valid_o or error_o.
// ----------------------------------------------------------------------------
module tb_can_frame_monitor;

    localparam int unsigned CPB = 8;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        frame_valid;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        ack_seen;
    logic        error;
    logic [2:0]  error_code;

    can_frame_monitor #(
        .CLKS_PER_BIT (8),
        .SAMPLE_POINT (5)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rx_i          (rx),
        .frame_valid_o (frame_valid),
        .id_o          (id),
        .rtr_o         (rtr),
        .dlc_o         (dlc),
        .data_o        (data),
        .ack_seen_o    (ack_seen),
        .error_o       (error),
        .error_code_o  (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [2:0]  code;
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    exp_t prev;
    logic tx[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (frame_valid || error)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, frame_valid, error}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("error_pulse", {63'd0, error}, {63'd0, e.is_err});
                check("frame_valid", {63'd0, frame_valid}, {63'd0, ~e.is_err});
                check("id", {53'd0, id}, {53'd0, e.id});
                check("rtr", {63'd0, rtr}, {63'd0, e.rtr});
                check("dlc", {60'd0, dlc}, {60'd0, e.dlc});
                check("data", data, e.data);
                check("ack_seen", {63'd0, ack_seen}, {63'd0, e.ack});
                if (e.is_err) check("error_code", {61'd0, error_code}, {61'd0, e.code});
            end
        end
    end

    // ---------------- expectations ----------------
    task automatic expect_frame(input logic [10:0] i, input logic r, input logic [3:0] d,
                                input logic [63:0] dat, input logic a);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = 3'd0;
        e.id     = i;
        e.rtr    = r;
        e.dlc    = d;
        e.data   = dat;
        e.ack    = a;
        exp_q.push_back(e);
        prev = e;
    endtask

    task automatic expect_error(input logic [2:0] c);
        exp_t e;
        e        = prev;
        e.is_err = 1'b1;
        e.code   = c;
        exp_q.push_back(e);
    endtask

    // ---------------- transmitter model ----------------
    task automatic build(input logic [10:0] i, input logic r, input logic ide,
                         input logic [3:0] d, input logic [63:0] dat, input logic a,
                         input logic flip, input logic del_dom);
        logic        u[$];
        logic [15:0] rem;
        int          nb;
        int          run;
        logic        lastb;
        u.delete();
        tx.delete();
        u.push_back(1'b0);
        for (int k = 10; k >= 0; k--) u.push_back(i[k]);
        u.push_back(r);
        u.push_back(ide);
        u.push_back(1'b0);
        for (int k = 3; k >= 0; k--) u.push_back(d[k]);
        nb = (d > 4'd8) ? 8 : int'(d);
        if (!r) for (int k = 0; k < 8 * nb; k++) u.push_back(dat[63 - k]);
        // remainder of M(x)*x^15 divided by x^15 + 0x4599
        rem = 16'h0;
        for (int k = 0; k < u.size() + 15; k++) begin
            rem = {rem[14:0], (k < u.size()) ? u[k] : 1'b0};
            if (rem[15]) rem = rem ^ 16'hC599;
        end
        if (flip) u[22] = ~u[22];
        for (int k = 14; k >= 0; k--) u.push_back(rem[k]);
        run   = 0;
        lastb = 1'b1;
        foreach (u[k]) begin
            tx.push_back(u[k]);
            if (u[k] == lastb) run++;
            else begin
                run   = 1;
                lastb = u[k];
            end
            if (run == 5) begin
                tx.push_back(~lastb);
                lastb = ~lastb;
                run   = 1;
            end
        end
        tx.push_back(~del_dom);
        tx.push_back(~a);
        for (int k = 0; k < 8; k++) tx.push_back(1'b1);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_tx();
        foreach (tx[k]) send_bit(tx[k]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send_bit(1'b1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 4000; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        prev  = '0;
        repeat (3) @(negedge clk);
        check("reset_id", {53'd0, id}, 64'd0);
        check("reset_outputs", {54'd0, frame_valid, error, error_code, rtr, ack_seen, dlc[2:0]}, 64'd0);
        check("reset_data", data, 64'd0);
        rst_n = 1'b1;
        idle(14);

        // basic data frame, ACK dominant
        expect_frame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        send_tx();
        idle(12);
        wait_drain();

        // all-zero frame, dense stuffing, ACK recessive
        expect_frame(11'h000, 1'b0, 4'd8, 64'd0, 1'b0);
        build(11'h000, 1'b0, 1'b0, 4'd8, 64'd0, 1'b0, 1'b0, 1'b0);
        send_tx();
        idle(12);
        wait_drain();

        // remote frame: DLC reported, no data bits
        expect_frame(11'h7F0, 1'b1, 4'd4, 64'd0, 1'b1);
        build(11'h7F0, 1'b1, 1'b0, 4'd4, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 1'b0);
        send_tx();
        idle(12);
        wait_drain();

        // six dominant bits inside ID
        expect_error(3'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 6; k++) send_bit(1'b0);
        idle(14);
        wait_drain();

        // short dominant glitch in IDLE is not a SOF
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        idle(3);
        expect_frame(11'h055, 1'b0, 4'd1, 64'hC300_0000_0000_0000, 1'b1);
        build(11'h055, 1'b0, 1'b0, 4'd1, 64'hC300_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        send_tx();
        idle(12);
        wait_drain();

        // DLC above 8: reported as received, 8 bytes decoded
        expect_frame(11'h5AA, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF, 1'b1);
        build(11'h5AA, 1'b0, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0);
        send_tx();
        idle(12);
        wait_drain();

        // flipped data bit -> CRC error
        expect_error(3'd2);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        send_tx();
        idle(14);
        wait_drain();

        // dominant CRC delimiter -> form error
        expect_error(3'd3);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        send_tx();
        idle(14);
        wait_drain();

        // extended frame -> IDE error
        expect_error(3'd4);
        build(11'h2B4, 1'b0, 1'b1, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        send_tx();
        idle(14);
        wait_drain();

        // reset in the middle of DATA
        build(11'h3C3, 1'b0, 1'b0, 4'd8, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) send_bit(tx[k]);
        rx    = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midreset_id", {53'd0, id}, 64'd0);
        check("midreset_dlc", {60'd0, dlc}, 64'd0);
        check("midreset_data", data, 64'd0);
        check("midreset_flags", {59'd0, frame_valid, error, rtr, ack_seen, |error_code}, 64'd0);
        prev = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        // no preceding idle: must be ignored
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        send_tx();
        idle(14);
        wait_drain();
        check("ignored_frame_id", {53'd0, id}, 64'd0);
        expect_frame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1);
        send_tx();
        idle(12);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "time limit");
    end

endmodule

// File: doc/can_frame_monitor.md
Name: can_frame_monitor

Overview:
- Passive bit-level CAN receiver for the testbench. Consumes one node's rx line of the simulated CAN bus and decodes standard (11-bit ID) data/remote frames.
- Reports decoded fields, the CRC result and protocol errors so benches can check traffic independently of the controller under test.
- Never drives the bus.

Parameters:
CLKS_PER_BIT, 8, clock cycles per CAN bit (>=4)
SAMPLE_POINT, 5, counter value within a bit at which the line is sampled (1..CLKS_PER_BIT-1)

Ports:
clk_i  input  1  clock
rst_n_i  input  1  reset, asynchronous, active-low
rx_i  input  1  bus level, 1=recessive, 0=dominant
frame_valid_o  output  1  one-cycle pulse, error-free frame completed
id_o  output  11  identifier of last valid frame
rtr_o  output  1  RTR bit of last valid frame
dlc_o  output  4  DLC of last valid frame
data_o  output  64  data bytes, first byte at [63:56], unused bytes zero
ack_seen_o  output  1  ACK slot sampled dominant in last valid frame
error_o  output  1  one-cycle pulse on protocol error
error_code_o  output  3  1=stuff, 2=CRC, 3=form, 4=IDE (extended) unsupported; held until next error

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous and active-low (rst_n_i).
- Reset: all outputs 0; state WAIT_IDLE; bit counter 0.
- Input path: rx_i passes a 2-flop synchronizer. rx_s denotes the synchronized value.
- Bit timing:
  - Counter runs 0..CLKS_PER_BIT-1 and wraps.
  - rx_s is sampled when counter==SAMPLE_POINT.
  - Hard sync: in IDLE, a 1->0 edge of rx_s sets counter to 0 in that cycle. No resynchronization inside the frame.
- States: WAIT_IDLE, IDLE, ID, RTR, IDE, R0, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF.
- WAIT_IDLE: needs 11 consecutive recessive samples, then IDLE. Any dominant sample restarts the count.
- IDLE: hard-sync edge starts a frame. A dominant sample at the next sample point is SOF, then go to ID. A recessive sample there is a glitch; stay in IDLE.
- Field lengths in destuffed bits, MSB first: ID 11, RTR 1, IDE 1, R0 1, DLC 4.
- DATA: 8*min(DLC,8) bits. Skipped entirely when RTR=1 or DLC=0.
- CRC: 15 bits.
- Then CRC_DEL 1, ACK 1, ACK_DEL 1, EOF 7.
- Destuffing (SOF through last CRC bit):
  - Track run length of equal destuffed-stream bits.
  - After 5 equal bits, the next sample is a stuff bit: dropped, run restarts at 1 with its value.
  - A stuff bit equal to the previous bit is a stuff error.
  - A stuff bit after the last CRC bit is still checked and removed.
- CRC:
  - CRC-15, polynomial 0x4599, init 0, over destuffed SOF..last data bit.
  - Received CRC is compared after the 15th CRC bit; mismatch is a CRC error.
- IDE=1 gives error code 4.
- Form errors: CRC_DEL, ACK_DEL or any EOF bit sampled dominant gives code 3.
- ACK slot value is captured; either level is legal.
- Data packing: received bytes shift into data_o image from [63:56] downward. Remaining bytes zero; data zero when RTR=1.
- On any error:
  - error_o pulses one cycle and error_code_o updates in the cycle after the offending sample.
  - Frame discarded; frame_valid_o not asserted; result outputs unchanged.
  - Go to WAIT_IDLE.
- After 7th EOF bit recessive:
  - frame_valid_o pulses one cycle.
  - id_o/rtr_o/dlc_o/data_o/ack_seen_o load in the same cycle and hold until the next valid frame.
  - Go to IDLE (intermission not enforced; SOF accepted immediately).
- DLC 9..15: reported as received, 8 data bytes decoded.
- Reset asserted mid-frame: immediate return to reset values, then WAIT_IDLE.

Test Plan:
- Reset, 11 recessive bits, frame ID 0x123 RTR 0 DLC 2 data A5 5A, correct CRC, ACK dominant -> one frame_valid_o pulse; id_o=0x123, dlc_o=2, data_o=0xA55A000000000000, ack_seen_o=1, error_o never high.
- ID 0x000 DLC 8 data all 0x00 (dense stuffing), ACK recessive -> valid; data_o=0, dlc_o=8, ack_seen_o=0.
- Remote frame ID 0x7F0 RTR 1 DLC 4 -> valid; rtr_o=1, dlc_o=4, data_o=0.
- Six consecutive dominant bits inside ID -> error_o pulse, code 1, no frame_valid_o. Following 11 recessive bits plus valid frame ID 0x055 -> decoded correctly.
- Flip one data bit of the first scenario's frame -> code 2. Second run with CRC delimiter dominant -> code 3. Frame with IDE=1 -> code 4. Previous valid outputs unchanged in all three.
- Assert rst_n_i during the DATA field -> outputs 0 immediately. After release, a frame without 11 preceding recessive bits is ignored; the next frame after idle decodes correctly.
